// File: rtl/ddram_pkg.sv
// Shared types and constants for the single-line DDRAM byte cache.
package ddram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_CMD  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR_CMD  = 2'd3
  } state_t;

  localparam logic [9:0] DDRAM_BASE = 10'b0011000000;
  localparam int         TAG_W      = 19;
  localparam int         CADDR_W    = TAG_W + 3;
  localparam int         WADDR_W    = 10 + TAG_W;

  function automatic logic [7:0] lane_sel(input logic [63:0] word, input logic [2:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

  function automatic logic [WADDR_W-1:0] word_addr(input logic [TAG_W-1:0] tag);
    return {DDRAM_BASE, tag};
  endfunction

endpackage

// File: rtl/ddram_if.sv
// Client byte port plus Avalon-style DDRAM master bus, bundled for the cache.
interface ddram_if;
  import ddram_pkg::*;

  logic               DDRAM_BUSY;
  logic [7:0]         DDRAM_BURSTCNT;
  logic [WADDR_W-1:0] DDRAM_ADDR;
  logic [63:0]        DDRAM_DOUT;
  logic               DDRAM_DOUT_READY;
  logic               DDRAM_RD;
  logic [63:0]        DDRAM_DIN;
  logic [7:0]         DDRAM_BE;
  logic               DDRAM_WE;

  logic [CADDR_W-1:0] addr;
  logic [7:0]         dout;
  logic [7:0]         din;
  logic               we;
  logic               rd;
  logic               ready;

  modport slave (
    input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY, addr, din, we, rd,
    output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE, dout, ready
  );

  modport master (
    output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY, addr, din, we, rd,
    input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE, dout, ready
  );

endinterface

// File: rtl/ddram.sv
// Byte-wide client port onto a 64-bit DDRAM bus with a one-line write-through
// read cache; requests are edge-triggered on rd/we and ready marks completion.
module ddram
  import ddram_pkg::*;
(
  input  logic   DDRAM_CLK,
  input  logic   reset,
  ddram_if.slave bus
);

  state_t             r_state, w_state_next;
  logic               r_rd_prev, r_we_prev;
  logic [63:0]        r_cache_data, w_cache_data_next;
  logic [TAG_W-1:0]   r_cache_tag, w_cache_tag_next;
  logic               r_cache_valid, w_cache_valid_next;
  logic [CADDR_W-1:0] r_addr, w_addr_next;
  logic [7:0]         r_din, w_din_next;
  logic [7:0]         r_dout, w_dout_next;
  logic               r_ready, w_ready_next;
  logic               r_ddram_rd, w_ddram_rd_next;
  logic               r_ddram_we, w_ddram_we_next;
  logic [7:0]         r_ddram_be, w_ddram_be_next;
  logic [WADDR_W-1:0] r_ddram_addr, w_ddram_addr_next;
  logic [63:0]        r_ddram_din, w_ddram_din_next;

  logic               w_rd_edge, w_we_edge;
  logic               w_hit_req, w_hit_pending;
  logic [63:0]        w_din_rep;
  logic [63:0]        w_wr_merge;

  assign w_rd_edge     = bus.rd & ~r_rd_prev;
  assign w_we_edge     = bus.we & ~r_we_prev;
  assign w_hit_req     = r_cache_valid && (r_cache_tag == bus.addr[CADDR_W-1:3]);
  assign w_hit_pending = r_cache_valid && (r_cache_tag == r_addr[CADDR_W-1:3]);

  // Write data goes out on every lane; BE picks the one that lands.
  // The merge view is the cached line with the pending byte patched in.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign w_din_rep[gi*8 +: 8]  = bus.din;
    assign w_wr_merge[gi*8 +: 8] = (r_addr[2:0] == 3'(gi)) ? r_din : r_cache_data[gi*8 +: 8];
  end

  always_comb begin
    w_state_next       = r_state;
    w_cache_data_next  = r_cache_data;
    w_cache_tag_next   = r_cache_tag;
    w_cache_valid_next = r_cache_valid;
    w_addr_next        = r_addr;
    w_din_next         = r_din;
    w_dout_next        = r_dout;
    w_ready_next       = r_ready;
    w_ddram_rd_next    = r_ddram_rd;
    w_ddram_we_next    = r_ddram_we;
    w_ddram_be_next    = r_ddram_be;
    w_ddram_addr_next  = r_ddram_addr;
    w_ddram_din_next   = r_ddram_din;

    unique case (r_state)
      ST_IDLE: begin
        // A write wins over a coincident read; the read edge is simply lost.
        if (w_we_edge) begin
          w_addr_next       = bus.addr;
          w_din_next        = bus.din;
          w_ddram_we_next   = 1'b1;
          w_ddram_be_next   = 8'b1 << bus.addr[2:0];
          w_ddram_addr_next = word_addr(bus.addr[CADDR_W-1:3]);
          w_ddram_din_next  = w_din_rep;
          w_ready_next      = 1'b0;
          w_state_next      = ST_WR_CMD;
        end else if (w_rd_edge) begin
          if (w_hit_req) begin
            w_dout_next = lane_sel(r_cache_data, bus.addr[2:0]);
          end else begin
            w_addr_next       = bus.addr;
            w_ddram_rd_next   = 1'b1;
            w_ddram_addr_next = word_addr(bus.addr[CADDR_W-1:3]);
            w_ready_next      = 1'b0;
            w_state_next      = ST_RD_CMD;
          end
        end
      end

      ST_RD_CMD: begin
        if (!bus.DDRAM_BUSY) begin
          w_ddram_rd_next = 1'b0;
          w_state_next    = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        if (bus.DDRAM_DOUT_READY) begin
          w_cache_data_next  = bus.DDRAM_DOUT;
          w_cache_tag_next   = r_addr[CADDR_W-1:3];
          w_cache_valid_next = 1'b1;
          w_dout_next        = lane_sel(bus.DDRAM_DOUT, r_addr[2:0]);
          w_ready_next       = 1'b1;
          w_state_next       = ST_IDLE;
        end
      end

      ST_WR_CMD: begin
        if (!bus.DDRAM_BUSY) begin
          w_ddram_we_next = 1'b0;
          w_ddram_be_next = 8'hFF;
          w_ready_next    = 1'b1;
          w_state_next    = ST_IDLE;
          // Write-through keeps a resident line coherent; misses never allocate.
          if (w_hit_pending) begin
            w_cache_data_next = w_wr_merge;
          end
        end
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_rd_prev     <= 1'b0;
      r_we_prev     <= 1'b0;
      r_cache_data  <= '0;
      r_cache_tag   <= '0;
      r_cache_valid <= 1'b0;
      r_addr        <= '0;
      r_din         <= '0;
      r_dout        <= '0;
      r_ready       <= 1'b1;
      r_ddram_rd    <= 1'b0;
      r_ddram_we    <= 1'b0;
      r_ddram_be    <= 8'hFF;
      r_ddram_addr  <= '0;
      r_ddram_din   <= '0;
    end else begin
      r_state       <= w_state_next;
      // Edge history tracks continuously so a level held through a busy
      // period does not fire once the block goes idle again.
      r_rd_prev     <= bus.rd;
      r_we_prev     <= bus.we;
      r_cache_data  <= w_cache_data_next;
      r_cache_tag   <= w_cache_tag_next;
      r_cache_valid <= w_cache_valid_next;
      r_addr        <= w_addr_next;
      r_din         <= w_din_next;
      r_dout        <= w_dout_next;
      r_ready       <= w_ready_next;
      r_ddram_rd    <= w_ddram_rd_next;
      r_ddram_we    <= w_ddram_we_next;
      r_ddram_be    <= w_ddram_be_next;
      r_ddram_addr  <= w_ddram_addr_next;
      r_ddram_din   <= w_ddram_din_next;
    end
  end

  assign bus.DDRAM_BURSTCNT = 8'd1;
  assign bus.DDRAM_ADDR     = r_ddram_addr;
  assign bus.DDRAM_RD       = r_ddram_rd;
  assign bus.DDRAM_WE       = r_ddram_we;
  assign bus.DDRAM_BE       = r_ddram_be;
  assign bus.DDRAM_DIN      = r_ddram_din;
  assign bus.dout           = r_dout;
  assign bus.ready          = r_ready;

endmodule

// File: tb/tb_ddram.sv
// Self-checking bench for ddram: DDRAM memory responder plus a byte-level
// reference of memory contents and cache residency.
module tb_ddram;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddram_if bus ();

  ddram u_dut (
    .DDRAM_CLK (clk),
    .reset     (rst),
    .bus       (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- memory contents ----------------
  logic [63:0] preset_words [int unsigned];
  logic [63:0] mem          [int unsigned];
  logic [7:0]  ref_bytes    [int unsigned];

  function automatic logic [63:0] base_word(input logic [28:0] wa);
    logic [31:0] h;
    if (preset_words.exists(32'(wa))) return preset_words[32'(wa)];
    h = 32'(wa) * 32'h9E3779B1;
    return {h ^ 32'h5A5A1234, ~h + 32'h0101_0101};
  endfunction

  function automatic logic [63:0] mem_read(input logic [28:0] wa);
    if (!mem.exists(32'(wa))) mem[32'(wa)] = base_word(wa);
    return mem[32'(wa)];
  endfunction

  function automatic logic [7:0] ref_byte(input logic [21:0] a);
    logic [63:0] w;
    if (ref_bytes.exists(32'(a))) return ref_bytes[32'(a)];
    w = base_word({10'b0011000000, a[21:3]});
    return w[a[2:0]*8 +: 8];
  endfunction

  // ---------------- DDRAM responder ----------------
  int          rd_cmds = 0, wr_cmds = 0, we_high = 0;
  int          busy_force = 0;
  bit          busy_rand = 0;
  bit          noise_en = 0;
  int          rd_lat_fixed = -1;
  bit          rd_pending = 0;
  int          rd_cnt = 0;
  logic [28:0] pend_wa;
  logic [28:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [7:0]  last_be = '0;
  logic [63:0] last_din = '0;

  initial begin
    logic [63:0] w;
    bus.DDRAM_BUSY       = 1'b0;
    bus.DDRAM_DOUT       = '0;
    bus.DDRAM_DOUT_READY = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.DDRAM_DOUT_READY = 1'b0;
      if (rd_pending) begin
        if (rd_cnt == 0) begin
          bus.DDRAM_DOUT       = mem_read(pend_wa);
          bus.DDRAM_DOUT_READY = 1'b1;
          rd_pending           = 1'b0;
        end else rd_cnt--;
      end else if (noise_en && $urandom_range(0, 7) == 0) begin
        bus.DDRAM_DOUT       = {$urandom, $urandom};
        bus.DDRAM_DOUT_READY = 1'b1;
      end
      if (busy_force > 0) begin
        bus.DDRAM_BUSY = 1'b1;
        busy_force--;
      end else bus.DDRAM_BUSY = busy_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
      @(negedge clk);
      if (rst) rd_pending = 1'b0;
      else begin
        if (bus.DDRAM_RD && !bus.DDRAM_BUSY) begin
          rd_cmds++;
          last_rd_addr = bus.DDRAM_ADDR;
          pend_wa      = bus.DDRAM_ADDR;
          rd_pending   = 1'b1;
          rd_cnt       = (rd_lat_fixed >= 0) ? rd_lat_fixed : $urandom_range(0, 3);
        end
        if (bus.DDRAM_WE) we_high++;
        if (bus.DDRAM_WE && !bus.DDRAM_BUSY) begin
          wr_cmds++;
          last_wr_addr = bus.DDRAM_ADDR;
          last_be      = bus.DDRAM_BE;
          last_din     = bus.DDRAM_DIN;
          w = mem_read(bus.DDRAM_ADDR);
          for (int b = 0; b < 8; b++)
            if (bus.DDRAM_BE[b]) w[b*8 +: 8] = bus.DDRAM_DIN[b*8 +: 8];
          mem[32'(bus.DDRAM_ADDR)] = w;
        end
      end
    end
  end

  // ---------------- client-side reference of cache residency ----------------
  bit          m_valid = 0;
  logic [18:0] m_tag   = '0;

  task automatic do_op(input bit do_rd, input bit do_wr, input logic [21:0] a,
                       input logic [7:0] d, input int force_busy, input bit rd_mid);
    int  rc0, wc0, wh0, cyc;
    bit  hit, saw_low;
    hit = m_valid && (m_tag == a[21:3]);
    rc0 = rd_cmds; wc0 = wr_cmds; wh0 = we_high;
    @(posedge clk); #1;
    bus.addr = a; bus.din = d; bus.rd = do_rd; bus.we = do_wr;
    @(negedge clk);
    if (force_busy > 0) busy_force = force_busy;
    @(posedge clk);
    @(negedge clk);
    saw_low = !bus.ready;
    if (rd_mid) bus.rd = 1'b1;
    cyc = 0;
    while (!bus.ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.ready) check("op_timeout", 64'(bus.ready), 64'd1);
    if (do_wr) begin
      check("wr_cmd_count", 64'(wr_cmds - wc0), 64'd1);
      check("wr_no_rd", 64'(rd_cmds - rc0), 64'd0);
      check("wr_ready_low", 64'(saw_low), 64'd1);
      check("wr_addr", 64'(last_wr_addr), 64'({10'b0011000000, a[21:3]}));
      check("wr_be", 64'(last_be), 64'(8'b1 << a[2:0]));
      check("wr_din", last_din, {8{d}});
      if (force_busy > 0) check("we_cycles", 64'(we_high - wh0), 64'(force_busy + 1));
      ref_bytes[32'(a)] = d;
      $display("[TB] wr%s addr=%h din=%h", do_rd ? "+rd" : "", a, d);
    end else begin
      check("rd_cmd_count", 64'(rd_cmds - rc0), hit ? 64'd0 : 64'd1);
      check("rd_ready_low", 64'(saw_low), hit ? 64'd0 : 64'd1);
      if (!hit) check("rd_addr", 64'(last_rd_addr), 64'({10'b0011000000, a[21:3]}));
      check("rd_dout", 64'(bus.dout), 64'(ref_byte(a)));
      if (!hit) begin
        m_valid = 1'b1;
        m_tag   = a[21:3];
      end
      $display("[TB] rd %s addr=%h dout=%h", hit ? "hit " : "miss", a, bus.dout);
    end
    @(posedge clk); #1;
    bus.rd = 1'b0; bus.we = 1'b0;
  endtask

  logic [18:0] tag_pool [4];

  initial begin
    int rc, cyc, kind;
    logic [21:0] a;
    bus.addr = '0; bus.din = '0; bus.rd = 1'b0; bus.we = 1'b0;
    preset_words[32'h0600_0000] = 64'h8877665544332211;
    tag_pool[0] = 19'h00000; tag_pool[1] = 19'h00002;
    tag_pool[2] = 19'h7FFFF; tag_pool[3] = 19'h12345;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_rd", 64'(bus.DDRAM_RD), 64'd0);
    check("rst_we", 64'(bus.DDRAM_WE), 64'd0);
    check("rst_be", 64'(bus.DDRAM_BE), 64'hFF);
    check("rst_addr", 64'(bus.DDRAM_ADDR), 64'd0);
    check("rst_din", bus.DDRAM_DIN, 64'd0);
    check("rst_dout", 64'(bus.dout), 64'd0);
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("burstcnt", 64'(bus.DDRAM_BURSTCNT), 64'd1);
    @(posedge clk); #1; rst = 1'b0;

    // Directed: miss, hit, busy write, write hit, simultaneous edges
    do_op(1, 0, 22'h000005, 8'h00, 0, 0);
    check("first_rd_addr", 64'(last_rd_addr), 64'h0600_0000);
    check("first_dout", 64'(bus.dout), 64'h66);
    do_op(1, 0, 22'h000002, 8'h00, 0, 0);
    check("hit_dout", 64'(bus.dout), 64'h33);
    do_op(0, 1, 22'h000003, 8'hAB, 3, 0);
    do_op(1, 0, 22'h000003, 8'h00, 0, 0);
    check("wr_hit_dout", 64'(bus.dout), 64'hAB);
    do_op(1, 1, 22'h000010, 8'h5C, 0, 0);

    // rd rising while busy must not fire later, even if still high at idle
    rc = rd_cmds;
    do_op(0, 1, 22'h000021, 8'h3E, 4, 1);
    repeat (4) @(negedge clk);
    check("busy_edge_ignored", 64'(rd_cmds - rc), 64'd0);
    check("busy_edge_ready", 64'(bus.ready), 64'd1);

    // Reset during RD_WAIT
    rd_lat_fixed = 20;
    rc = rd_cmds;
    @(posedge clk); #1;
    bus.addr = 22'h000100; bus.rd = 1'b1;
    cyc = 0;
    while (rd_cmds == rc && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("rdwait_reached", 64'(rd_cmds - rc), 64'd1);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("abort_rd", 64'(bus.DDRAM_RD), 64'd0);
    check("abort_ready", 64'(bus.ready), 64'd1);
    @(posedge clk); #1; rst = 1'b0; bus.rd = 1'b0;
    m_valid = 1'b0;
    rd_lat_fixed = -1;
    repeat (3) @(posedge clk);
    do_op(1, 0, 22'h000005, 8'h00, 0, 0);
    $display("[TB] post-reset read of old line done");

    // Randomised traffic with bus back-pressure and stray DOUT_READY
    busy_rand = 1;
    noise_en  = 1;
    for (int i = 0; i < 250; i++) begin
      a = {tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7))};
      kind = $urandom_range(0, 9);
      if (kind < 5)      do_op(1, 0, a, 8'h00, 0, 0);
      else if (kind < 9) do_op(0, 1, a, 8'($urandom), 0, 0);
      else               do_op(1, 1, a, 8'($urandom), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddram.md
DDRAM -- requirements
Module: ddram

Interface
REQ-001 DDRAM_CLK  in  1  sole clock; all logic on its rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 DDRAM_BUSY  in  1  Avalon waitrequest; a command is accepted only in a cycle where it is low.
REQ-004 DDRAM_BURSTCNT  out  8  burst length; constant 1.
REQ-005 DDRAM_ADDR  out  29  64-bit word address = {10'b0011000000, addr[21:3]} (byte base 0x3000_0000).
REQ-006 DDRAM_DOUT  in  64  read data.
REQ-007 DDRAM_DOUT_READY  in  1  read data valid strobe.
REQ-008 DDRAM_RD  out  1  read command.
REQ-009 DDRAM_DIN  out  64  write data = din replicated 8 times.
REQ-010 DDRAM_BE  out  8  byte enables = one-hot (1 << addr[2:0]) on writes; 8'hFF otherwise.
REQ-011 DDRAM_WE  out  1  write command.
REQ-012 addr  in  22  client byte address.
REQ-013 dout  out  8  client read byte.
REQ-014 din  in  8  client write byte.
REQ-015 we  in  1  write request; acts on its rising edge.
REQ-016 rd  in  1  read request; acts on its rising edge.
REQ-017 ready  out  1  high = idle, result valid; low = operation in progress.

Function
REQ-018 One-line cache: 64-bit data, 19-bit tag (addr[21:3]), valid bit.
REQ-019 States: IDLE, RD_CMD, RD_WAIT, WR_CMD.
REQ-020 In IDLE, registered previous values of rd/we detect rising edges; edges arriving while ready is low are ignored.
REQ-021 Simultaneous rd and we rising edges: the write is serviced and the read is dropped.
REQ-022 Read hit (valid, tag equal): dout = cached byte addr[2:0], registered one cycle after the edge; ready stays high; no DDRAM command.
REQ-023 Read miss: ready low the cycle after the edge; go to RD_CMD and assert DDRAM_RD with the address.
REQ-024 RD_CMD: hold DDRAM_RD and DDRAM_ADDR until a cycle with DDRAM_BUSY low, then deassert DDRAM_RD and go to RD_WAIT.
REQ-025 RD_WAIT: on DDRAM_DOUT_READY, load the cache (data, tag, valid = 1), set dout to the selected byte, set ready high, and return to IDLE.
REQ-026 Write: on the we edge go to WR_CMD with ready low, assert DDRAM_WE with DIN, BE and ADDR, and hold them until a cycle with BUSY low.
REQ-027 On write accept: deassert DDRAM_WE, set ready high, return to IDLE; on a tag hit, update the cached byte addr[2:0] with din in the same cycle.
REQ-028 Write-through only; the cache never holds dirty data; a write miss does not allocate.
REQ-029 Byte lane k corresponds to bits 8k+7..8k (little-endian).
REQ-030 DDRAM_DOUT_READY outside RD_WAIT is ignored.

Reset
REQ-031 Reset values: DDRAM_RD = 0, DDRAM_WE = 0, DDRAM_BE = 8'hFF, DDRAM_ADDR = 0, DDRAM_DIN = 0, dout = 0, ready = 1, cache valid = 0, state = IDLE, rd/we edge registers = 0.
REQ-032 Reset mid-operation aborts the command immediately; no further response is expected.

Structure
REQ-033 A shared package holds the state enum, the base-address constant 10'b0011000000 and the tag width (19).
REQ-034 Single flat module; no sub-module.

Verification
REQ-035 Reset, then rd edge at addr 0x000005 with the memory word 0x8877665544332211 -> one DDRAM_RD at 29'h0600_0000, ready low until DOUT_READY, then dout = 0x66 and ready = 1.
REQ-036 Then rd edge at addr 0x000002 -> no DDRAM_RD, dout = 0x33 after 1 cycle, ready never low.
REQ-037 we edge with addr 0x000003, din 0xAB, BUSY held high 3 cycles -> DDRAM_WE held 4 cycles, BE = 8'h08, DIN = 0xABAB..AB, ready high on accept; a following read of 0x000003 hits and returns 0xAB.
REQ-038 Simultaneous rd and we edges at addr 0x000010 -> only DDRAM_WE issues, no DDRAM_RD.
REQ-039 Reset asserted during RD_WAIT -> DDRAM_RD = 0, ready = 1, valid = 0; the next read of the previously cached line misses.
